// File: rtl/iir_sample_pacer.sv
// iir_sample_pacer: input conditioning stage in front of the opti_sos biquad.
// Buffers Q2.22 samples in a FIFO, applies optional rounded headroom shift and
// issues them as single-cycle pulses spaced exactly MIN_GAP cycles apart, so
// each sample enters the section only after the previous one's feedback closed.
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   in_valid/in_data/in_ready   source handshake; in_ready is combinational
//   out_valid/out_data          issue pulse and scaled sample (held between pulses)
//   flush          synchronous clear of FIFO and pacing state
//   clr_overflow   clears the sticky overflow flag
//   fill_level     registered FIFO occupancy, 0..FIFO_DEPTH
//   overflow       sticky: in_valid seen while in_ready was low
module iir_sample_pacer #(
  parameter int unsigned DATA_W     = 24,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned MIN_GAP    = 16,
  parameter int unsigned HEADROOM   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  input  logic              clr_overflow,
  output logic [ADDR_W:0]   fill_level,
  output logic              overflow
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned GAP_W = $clog2(MIN_GAP);
  localparam logic [DATA_W:0] RND = (DATA_W+1)'((2 ** HEADROOM) / 2);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [GAP_W-1:0]  gap_cnt;
  logic [GAP_W-1:0]  gap_nxt;
  logic              pop;
  logic              full;
  logic              empty;
  logic              wr_en;
  logic [DATA_W-1:0] rd_data;
  logic signed [DATA_W:0] rnd_sum;
  logic [DATA_W-1:0] scaled;

  assign full       = (count == CNT_W'(FIFO_DEPTH));
  assign empty      = (count == '0);
  assign in_ready   = !full && !flush;
  assign wr_en      = in_valid && in_ready;
  assign fill_level = count;
  assign rd_data    = mem[rd_ptr];

  // Rounded arithmetic shift, one extra bit so the rounding add cannot wrap
  always_comb begin
    rnd_sum = $signed({rd_data[DATA_W-1], rd_data}) + $signed(RND);
    scaled  = DATA_W'(rnd_sum >>> HEADROOM);
  end

  // Next-state logic; pop happens on every transition into ISSUE
  always_comb begin
    state_nxt = state;
    gap_nxt   = gap_cnt;
    pop       = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          state_nxt = S_ISSUE;
          pop       = 1'b1;
        end
      end
      S_ISSUE: begin
        gap_nxt   = GAP_W'(MIN_GAP - 2);
        state_nxt = S_GAP;
      end
      S_GAP: begin
        if (gap_cnt == '0) begin
          if (!empty) begin
            state_nxt = S_ISSUE;
            pop       = 1'b1;
          end else begin
            state_nxt = S_IDLE;
          end
        end else begin
          gap_nxt = gap_cnt - GAP_W'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (flush) begin
      state_nxt = S_IDLE;
      gap_nxt   = '0;
      pop       = 1'b0;
    end
  end

  // FSM state, pacing counter and registered issue outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      gap_cnt   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state     <= state_nxt;
      gap_cnt   <= gap_nxt;
      out_valid <= (state_nxt == S_ISSUE);
      if (pop) begin
        out_data <= scaled;
      end
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      count <= count + CNT_W'(wr_en) - CNT_W'(pop);
    end
  end

  // FIFO storage, not reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Sticky overflow; a new overflow wins over a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (in_valid && !in_ready && !flush) begin
      overflow <= 1'b1;
    end else if (clr_overflow) begin
      overflow <= 1'b0;
    end
  end

endmodule
